// File: rtl/integral_image.sv
// Integral-image builder: accepts one raster-order 8-bit frame and writes ii(x,y)
// to the downstream integral-image RAM, one word per pixel, pulsing frame_done at the end.
module integral_image #(
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               pix_valid,
   input  logic [7:0]         pix_data,
   output logic               pix_ready,
   output logic               ii_wr_en,
   output logic [14:0]        ii_wr_addr,
   output logic signed [20:0] ii_wr_data,
   output logic               busy,
   output logic               frame_done
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   // A frame that could overflow 21 bits or the 15-bit address space is rejected at elaboration.
   if ((WIDTH < 2) || (HEIGHT < 2) || (WIDTH * HEIGHT > 32768) ||
       (WIDTH * HEIGHT * 255 > 1048575)) begin : g_param_check
      $fatal(1, "integral_image: WIDTH/HEIGHT out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          start_z;
   logic          start_edge;
   logic          hs;
   logic          last_x;
   logic          last_px;
   logic          busy_nxt;
   logic          frame_done_nxt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [14:0]   addr;
   logic [20:0]   row_sum;
   logic [20:0]   row_sum_nxt;
   logic [20:0]   above;
   logic [20:0]   ii_val;
   logic [20:0]   line_buf [WIDTH];

   assign start_edge = start && !start_z && (state == S_IDLE);
   assign hs         = pix_valid && pix_ready;
   assign last_x     = (x == XW'(WIDTH - 1));
   assign last_px    = last_x && (y == YW'(HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_edge)     state_nxt = S_ACCUM;
         S_ACCUM: if (hs && last_px)  state_nxt = S_DONE;
         S_DONE:                      state_nxt = S_IDLE;
         default:                     state_nxt = S_IDLE;
      endcase
   end

   // pix_ready is decoded straight from state so a pixel can be taken the cycle ACCUM is entered.
   always_comb begin
      pix_ready      = 1'b0;
      frame_done_nxt = 1'b0;
      busy_nxt       = (state_nxt != S_IDLE);
      case (state)
         S_ACCUM: pix_ready      = 1'b1;
         S_DONE:  frame_done_nxt = 1'b1;
         default: ;
      endcase
   end

   // Row 0 ignores the line buffer, so its stale contents from a previous frame never leak in.
   always_comb begin
      row_sum_nxt = ((x == '0) ? 21'd0 : row_sum) + {13'd0, pix_data};
      above       = (y == '0) ? 21'd0 : line_buf[x];
      ii_val      = row_sum_nxt + above;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_z    <= 1'b0;
         ii_wr_en   <= 1'b0;
         ii_wr_addr <= '0;
         ii_wr_data <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         x          <= '0;
         y          <= '0;
         addr       <= '0;
         row_sum    <= '0;
      end else begin
         start_z    <= start;
         ii_wr_en   <= hs;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
         if (start_edge) begin
            x       <= '0;
            y       <= '0;
            addr    <= '0;
            row_sum <= '0;
         end else if (hs) begin
            ii_wr_addr <= addr;
            ii_wr_data <= signed'(ii_val);
            row_sum    <= row_sum_nxt;
            addr       <= addr + 15'd1;
            if (last_x) begin
               x <= '0;
               y <= y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end
      end
   end

   // NOTE: the line buffer has no reset; a storage array with a reset cannot map to RAM,
   // and every entry is written before it is read within a frame.
   always_ff @(posedge clk) begin
      if (hs) line_buf[x] <= ii_val;
   end

endmodule

// File: tb/tb_integral_image.sv
// Directed bench for integral_image: a 4x4 instance for the detailed frames and a
// default 64x64 instance for the saturated-frame check, sharing the pixel stream.
module tb_integral_image;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              start4;
   logic              start64;
   logic              pix_valid;
   logic [7:0]        pix_data;
   logic              rdy4, wr_en4, busy4, fd4;
   logic [14:0]       addr4;
   logic signed [20:0] data4;
   logic              rdy64, wr_en64, busy64, fd64;
   logic [14:0]       addr64;
   logic signed [20:0] data64;

   integral_image #(.WIDTH(4), .HEIGHT(4)) dut (
      .clk(clk), .rst(rst), .start(start4), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(rdy4), .ii_wr_en(wr_en4), .ii_wr_addr(addr4), .ii_wr_data(data4),
      .busy(busy4), .frame_done(fd4)
   );

   integral_image dut64 (
      .clk(clk), .rst(rst), .start(start64), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_ready(rdy64), .ii_wr_en(wr_en64), .ii_wr_addr(addr64), .ii_wr_data(data64),
      .busy(busy64), .frame_done(fd64)
   );

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   int   cyc = 0;
   wr_t  wq4[$];
   wr_t  wq64[$];
   int   hsq[$];
   int   fdq4[$];
   int   fdq64[$];
   int   brise4, brise64, bfall4, bfall64;
   logic busy4_q = 1'b0;
   logic busy64_q = 1'b0;
   int   exp_ii[];
   int   n_tests = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event logger, sampled on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (pix_valid === 1'b1 && (rdy4 === 1'b1 || rdy64 === 1'b1)) hsq.push_back(cyc);
      if (wr_en4 === 1'b1)  wq4.push_back(wr_t'{cyc, int'(addr4), int'(data4)});
      if (wr_en64 === 1'b1) wq64.push_back(wr_t'{cyc, int'(addr64), int'(data64)});
      if (fd4 === 1'b1)  fdq4.push_back(cyc);
      if (fd64 === 1'b1) fdq64.push_back(cyc);
      if (busy4 === 1'b1 && busy4_q !== 1'b1) brise4++;
      if (busy4 === 1'b0 && busy4_q === 1'b1) bfall4 = cyc;
      if (busy64 === 1'b1 && busy64_q !== 1'b1) brise64++;
      if (busy64 === 1'b0 && busy64_q === 1'b1) bfall64 = cyc;
      busy4_q  = busy4;
      busy64_q = busy64;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   function automatic int pixval(input int mode, input int k);
      case (mode)
         0:       return 1;
         1:       return k;
         2:       return 255;
         default: return 9;
      endcase
   endfunction

   // Reference: all-ones frames use the closed form, others the 2-D recurrence.
   task automatic build_model(input int w, input int h, input int mode);
      exp_ii = new[w * h];
      for (int yy = 0; yy < h; yy++) begin
         for (int xx = 0; xx < w; xx++) begin
            int k = yy * w + xx;
            int v;
            if (mode == 0) begin
               v = (xx + 1) * (yy + 1);
            end else begin
               v = pixval(mode, k);
               if (xx > 0) v += exp_ii[k - 1];
               if (yy > 0) v += exp_ii[k - w];
               if (xx > 0 && yy > 0) v -= exp_ii[k - w - 1];
            end
            exp_ii[k] = v;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wq4.delete();
      wq64.delete();
      hsq.delete();
      fdq4.delete();
      fdq64.delete();
      brise4  = 0;
      brise64 = 0;
      bfall4  = -1;
      bfall64 = -1;
   endtask

   task automatic do_start(input bit big, input bit hold);
      if (big) start64 = 1'b1;
      else     start4  = 1'b1;
      tick();
      if (!hold) begin
         start4  = 1'b0;
         start64 = 1'b0;
      end
      check(big ? "start_busy64" : "start_busy4", big ? busy64 : busy4, 1);
   endtask

   task automatic send_frame(input int mode, input int n, input bit stall, input bit big);
      int i = 0;
      int guard = 0;
      bit acc;
      while (i < n && guard < n * 4 + 100) begin
         if (stall && ((guard % 2 == 1) || ($urandom_range(0, 3) == 0))) begin
            pix_valid = 1'b0;
         end else begin
            pix_valid = 1'b1;
            pix_data  = 8'(pixval(mode, i));
         end
         @(negedge clk);
         acc = pix_valid && (big ? rdy64 : rdy4);
         tick();
         guard++;
         if (acc) i++;
      end
      pix_valid = 1'b0;
      check("pixels_accepted", i, n);
   endtask

   task automatic verify(input string fr, input int w, input int h, input bit big, input int mode);
      wr_t q[$];
      int  fq[$];
      int  n = w * h;
      int  bad = 0;
      int  last;
      build_model(w, h, mode);
      if (big) begin
         q  = wq64;
         fq = fdq64;
      end else begin
         q  = wq4;
         fq = fdq4;
      end
      check({fr, "_nwrites"}, q.size(), n);
      check({fr, "_nhandshakes"}, hsq.size(), n);
      check({fr, "_other_dut_writes"}, big ? wq4.size() : wq64.size(), 0);
      for (int k = 0; k < q.size() && k < n && k < hsq.size(); k++) begin
         if (big) begin
            if (q[k].addr != k || q[k].data != exp_ii[k] || q[k].cyc != hsq[k] + 1) bad++;
         end else begin
            check($sformatf("%s_addr[%0d]", fr, k), q[k].addr, k);
            check($sformatf("%s_data[%0d]", fr, k), q[k].data, exp_ii[k]);
            check($sformatf("%s_latency[%0d]", fr, k), q[k].cyc, hsq[k] + 1);
         end
      end
      if (big) check({fr, "_bad_writes"}, bad, 0);
      last = (hsq.size() > 0) ? hsq[hsq.size() - 1] : -100;
      check({fr, "_frame_done_count"}, fq.size(), 1);
      check({fr, "_frame_done_cycle"}, (fq.size() > 0) ? fq[0] : -1, last + 2);
      check({fr, "_busy_fall_cycle"}, big ? bfall64 : bfall4, last + 2);
   endtask

   initial begin
      int span;
      int minv;
      rst       = 1'b1;
      start4    = 1'b0;
      start64   = 1'b0;
      pix_valid = 1'b1;
      pix_data  = 8'hAA;
      clear_logs();
      repeat (3) tick();
      check("rst_pix_ready", rdy4, 0);
      check("rst_wr_en", wr_en4, 0);
      check("rst_wr_addr", addr4, 0);
      check("rst_wr_data", data4, 0);
      check("rst_busy", busy4, 0);
      check("rst_frame_done", fd4, 0);
      check("rst_busy64", busy64, 0);

      // pix_valid while idle must be ignored
      rst = 1'b0;
      clear_logs();
      repeat (3) tick();
      check("idle_pix_ready", rdy4, 0);
      check("idle_writes", wq4.size() + wq64.size(), 0);
      pix_valid = 1'b0;

      // Frame A: all ones, unstalled, start held high across and after the frame
      clear_logs();
      do_start(0, 1);
      send_frame(0, 16, 0, 0);
      repeat (6) tick();
      verify("A", 4, 4, 0, 0);
      check("A_addr15", (wq4.size() > 15) ? wq4[15].data : -1, 16);
      span = (wq4.size() > 0) ? wq4[wq4.size() - 1].cyc - wq4[0].cyc : -1;
      check("A_consecutive", span, 15);
      check("A_single_busy_period", brise4, 1);
      check("A_idle_with_start_high", busy4, 0);
      start4 = 1'b0;
      tick();

      // Frame B: pixel value equals its address
      clear_logs();
      do_start(0, 0);
      send_frame(1, 16, 0, 0);
      repeat (4) tick();
      verify("B", 4, 4, 0, 1);
      check("B_addr5", (wq4.size() > 5) ? wq4[5].data : -1, 10);
      check("B_addr15", (wq4.size() > 15) ? wq4[15].data : -1, 120);
      check("B_restart_busy", brise4, 1);

      // Frame C: all ones with pix_valid stalls
      clear_logs();
      do_start(0, 0);
      send_frame(0, 16, 1, 0);
      repeat (4) tick();
      verify("C", 4, 4, 0, 0);
      span = (wq4.size() > 0) ? wq4[wq4.size() - 1].cyc - wq4[0].cyc : -1;
      check("C_gaps_present", span > 15, 1);

      // Reset after 7 pixels of value 9, then a clean frame
      clear_logs();
      do_start(0, 0);
      send_frame(3, 7, 0, 0);
      rst       = 1'b1;
      pix_valid = 1'b1;
      tick();
      check("midrst_pix_ready", rdy4, 0);
      check("midrst_wr_en", wr_en4, 0);
      check("midrst_wr_addr", addr4, 0);
      check("midrst_wr_data", data4, 0);
      check("midrst_busy", busy4, 0);
      check("midrst_frame_done", fd4, 0);
      rst = 1'b0;
      wq4.delete();
      repeat (3) tick();
      check("midrst_no_writes", wq4.size(), 0);
      pix_valid = 1'b0;
      clear_logs();
      do_start(0, 0);
      send_frame(0, 16, 0, 0);
      repeat (4) tick();
      verify("R", 4, 4, 0, 0);

      // Default 64x64 frame, all pixels 255
      clear_logs();
      do_start(1, 0);
      send_frame(2, 4096, 0, 1);
      repeat (4) tick();
      verify("S", 64, 64, 1, 2);
      check("S_addr63", (wq64.size() > 63) ? wq64[63].data : -1, 16320);
      check("S_addr4095", (wq64.size() > 4095) ? wq64[4095].data : -1, 1044480);
      minv = 0;
      foreach (wq64[k]) if (wq64[k].data < minv) minv = wq64[k].data;
      check("S_never_negative", minv, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
